// File: rtl/mem_stage_dm.sv
// Data memory for the MEM stage of a 5-stage MIPS pipeline.
// Word-organised array with byte/half/word stores, sign/zero-extended loads,
// a zero-latency combinational read path and an asynchronously cleared array.
//
// Handshake: there is no valid/ready pairing here. MemWrite qualifies a store
// for the next rising edge; the read path is always live and RD/AlignErr
// describe the current inputs every cycle.
module mem_stage_dm #(
  parameter int DEPTH_LOG2 = 10,
  parameter bit TRACE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  output logic [31:0] RD,
  output logic        AlignErr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           word;
  logic [15:0]           sel_half;
  logic [7:0]            sel_byte;
  logic                  st_err;
  logic                  ld_err;
  logic                  wr_en_d;
  logic [31:0]           wr_data_d;

  // Upper address bits are dropped, so addresses wrap modulo the depth.
  assign idx      = Addr[DEPTH_LOG2+1:2];
  assign word     = mem_q[idx];
  assign AlignErr = st_err | ld_err;

  // Alignment checks: stores only matter when MemWrite is set, loads always.
  always_comb begin
    st_err = 1'b0;
    ld_err = 1'b0;
    if (MemWrite) begin
      case (StoreType)
        2'b00:   st_err = |Addr[1:0];
        2'b01:   st_err = Addr[0];
        default: st_err = 1'b0;
      endcase
    end
    case (LoadType)
      3'b001, 3'b010: ld_err = Addr[0];
      3'b011, 3'b100: ld_err = 1'b0;
      default:        ld_err = |Addr[1:0];
    endcase
  end

  // Read path: select half/byte from the addressed word and extend it.
  always_comb begin
    sel_half = Addr[1] ? word[31:16] : word[15:0];
    sel_byte = word[7:0];
    case (Addr[1:0])
      2'b00:   sel_byte = word[7:0];
      2'b01:   sel_byte = word[15:8];
      2'b10:   sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    case (LoadType)
      3'b001:  RD = {{16{sel_half[15]}}, sel_half};
      3'b010:  RD = {16'h0000, sel_half};
      3'b011:  RD = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  RD = {24'h000000, sel_byte};
      default: RD = word;
    endcase
  end

  // Store merge: build the new word from the current contents and WD.
  always_comb begin
    wr_data_d = word;
    wr_en_d   = MemWrite & ~st_err;
    case (StoreType)
      2'b00: wr_data_d = WD;
      2'b01: begin
        if (Addr[1]) wr_data_d[31:16] = WD[15:0];
        else         wr_data_d[15:0]  = WD[15:0];
      end
      2'b10: begin
        case (Addr[1:0])
          2'b00:   wr_data_d[7:0]   = WD[7:0];
          2'b01:   wr_data_d[15:8]  = WD[7:0];
          2'b10:   wr_data_d[23:16] = WD[7:0];
          default: wr_data_d[31:24] = WD[7:0];
        endcase
      end
      default: wr_en_d = 1'b0;
    endcase
  end

  // Array storage: asynchronous clear wins over any store in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_d) begin
      mem_q[idx] <= wr_data_d;
    end
  end

`ifndef SYNTHESIS
  // Trace every committed store with its merged word.
  always @(posedge clk) begin
    if (TRACE_EN && reset && wr_en_d)
      $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, wr_data_d);
  end
`endif

endmodule

// File: tb/tb_mem_stage_dm.sv
// Bench for mem_stage_dm: directed spec scenarios plus random traffic,
// checked every cycle against a behavioural word-array model.
module tb_mem_stage_dm;

  localparam int DEPTH = 1024;
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
  localparam logic [1:0] SW = 2'd0, SH = 2'd1, SB = 2'd2, SR = 2'd3;

  logic        clk;
  logic        reset;
  logic [31:0] PC, Addr, WD;
  logic        MemWrite;
  logic [1:0]  StoreType;
  logic [2:0]  LoadType;
  logic [31:0] RD;
  logic        AlignErr;

  logic [31:0] model_mem [DEPTH];
  logic [32:0] exp_q[$];
  string       exp_name_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        check_en = 1'b0;

  mem_stage_dm #(.DEPTH_LOG2(10), .TRACE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Addr(Addr), .WD(WD),
    .MemWrite(MemWrite), .StoreType(StoreType), .LoadType(LoadType),
    .RD(RD), .AlignErr(AlignErr)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  function automatic int word_index(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_rd();
    logic [31:0] w, h, b;
    w = model_mem[word_index(Addr)];
    h = (w >> (16 * ((Addr / 2) % 2))) & 32'h0000FFFF;
    b = (w >> (8 * (Addr % 4))) & 32'h000000FF;
    case (LoadType)
      LH:      return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      LHU:     return h;
      LB:      return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      LBU:     return b;
      default: return w;
    endcase
  endfunction

  function automatic logic model_st_err();
    if (!MemWrite) return 1'b0;
    if (StoreType == SW) return (Addr % 4) != 0;
    if (StoreType == SH) return (Addr % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic model_ae();
    logic ld;
    if (LoadType == LH || LoadType == LHU)      ld = (Addr % 2) != 0;
    else if (LoadType == LB || LoadType == LBU) ld = 1'b0;
    else                                        ld = (Addr % 4) != 0;
    return ld | model_st_err();
  endfunction

  // Model store: masked merge at the edge when the store is legal.
  always @(posedge clk) begin
    logic [31:0] mask;
    int          sh;
    if (reset && MemWrite && !model_st_err() && StoreType != SR) begin
      if (StoreType == SW) begin
        mask = 32'hFFFFFFFF; sh = 0;
      end else if (StoreType == SH) begin
        sh = 16 * ((Addr / 2) % 2); mask = 32'h0000FFFF << sh;
      end else begin
        sh = 8 * (Addr % 4); mask = 32'h000000FF << sh;
      end
      model_mem[word_index(Addr)] = (model_mem[word_index(Addr)] & ~mask) | ((WD << sh) & mask);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t addr=%08h lt=%0d)", nm, act, exp, $time, Addr, LoadType);
  endtask

  // Compare process: DUT vs model every cycle, plus literal pins.
  always @(negedge clk) begin
    logic [31:0] m_rd;
    logic        m_ae;
    logic [32:0] lit;
    string       nm;
    if (check_en) begin
      m_rd = model_rd();
      m_ae = model_ae();
      check("rd_vs_model", RD, m_rd);
      check("ae_vs_model", {31'b0, AlignErr}, {31'b0, m_ae});
      if (exp_q.size() > 0) begin
        lit = exp_q.pop_front();
        nm  = exp_name_q.pop_front();
        check({nm, "_rd"}, RD, lit[31:0]);
        check({nm, "_ae"}, {31'b0, AlignErr}, {31'b0, lit[32]});
        check({nm, "_model"}, m_rd, lit[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic we,
                    input logic [1:0] st, input logic [2:0] lt,
                    input string nm, input logic lit_en, input logic [32:0] lit);
    @(posedge clk);
    #1;
    PC = PC + 32'd4; Addr = a; WD = d; MemWrite = we; StoreType = st; LoadType = lt;
    if (lit_en) begin
      exp_q.push_back(lit);
      exp_name_q.push_back(nm);
    end
  endtask

  initial begin
    model_clear();
    reset = 1'b1; PC = 32'h00400000; Addr = 32'h10; WD = 32'hDEADBEEF;
    MemWrite = 1'b1; StoreType = SW; LoadType = LW;
    #1 reset = 1'b0;
    check_en = 1'b1;

    // Reset held with a pending store for three edges
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; MemWrite = 1'b0; Addr = 32'h10; LoadType = LW;
    exp_q.push_back({1'b0, 32'h0}); exp_name_q.push_back("reset_lw10");

    // Word store / load; RD shows old contents during the store cycle
    op(32'h20, 32'h12345678, 1, SW, LW, "sw20_old", 1, {1'b0, 32'h00000000});
    op(32'h20, 32'h0, 0, SW, LW, "lw20", 1, {1'b0, 32'h12345678});

    // Sub-word merges
    op(32'h21, 32'h000000AB, 1, SB, LBU, "sb21", 0, '0);
    op(32'h20, 32'h0, 0, SW, LW, "lw20_sb", 1, {1'b0, 32'h1234AB78});
    op(32'h22, 32'h0000CDEF, 1, SH, LHU, "sh22", 0, '0);
    op(32'h20, 32'h0, 0, SW, LW, "lw20_sh", 1, {1'b0, 32'hCDEFAB78});

    // Load extension
    op(32'h21, 32'h0, 0, SW, LB,  "lb21",  1, {1'b0, 32'hFFFFFFAB});
    op(32'h21, 32'h0, 0, SW, LBU, "lbu21", 1, {1'b0, 32'h000000AB});
    op(32'h22, 32'h0, 0, SW, LH,  "lh22",  1, {1'b0, 32'hFFFFCDEF});
    op(32'h22, 32'h0, 0, SW, LHU, "lhu22", 1, {1'b0, 32'h0000CDEF});
    op(32'h23, 32'h0, 0, SW, LH,  "lh23_mis", 1, {1'b1, 32'hFFFFCDEF});

    // Misalignment
    op(32'h30, 32'h11223344, 1, SW, LW, "sw30", 0, '0);
    op(32'h31, 32'hFFFFFFFF, 1, SW, LBU, "sw31_mis", 1, {1'b1, 32'h00000033});
    op(32'h30, 32'h0, 0, SW, LW, "lw30_a", 1, {1'b0, 32'h11223344});
    op(32'h33, 32'h0000FFFF, 1, SH, LBU, "sh33_mis", 1, {1'b1, 32'h00000011});
    op(32'h30, 32'h0, 0, SW, LW, "lw30_b", 1, {1'b0, 32'h11223344});
    op(32'h33, 32'h00000099, 1, SB, LBU, "sb33", 1, {1'b0, 32'h00000011});
    op(32'h30, 32'h0, 0, SW, LW, "lw30_c", 1, {1'b0, 32'h99223344});
    op(32'h31, 32'h0, 0, SW, LW, "lw31_mis", 1, {1'b1, 32'h99223344});
    op(32'h30, 32'h0, 1, SR, LW, "st_rsvd", 0, '0);
    op(32'h30, 32'h0, 0, SW, LW, "lw30_d", 1, {1'b0, 32'h99223344});

    // Back-to-back byte stores to one word
    op(32'h40, 32'h00000011, 1, SB, LW, "b2b_0", 0, '0);
    op(32'h41, 32'h00000022, 1, SB, LW, "b2b_1", 0, '0);
    op(32'h42, 32'h00003344, 1, SH, LW, "b2b_2", 0, '0);
    op(32'h40, 32'h0, 0, SW, LW, "lw40", 1, {1'b0, 32'h33442211});

    // Wrap-around and same-cycle read
    op(32'h1000, 32'h5A5A5A5A, 1, SW, LW, "sw1000_old", 1, {1'b0, 32'h00000000});
    op(32'h0, 32'h0, 0, SW, LW, "lw0_wrap", 1, {1'b0, 32'h5A5A5A5A});

    // Random traffic over a small window with random wrap bits
    for (int n = 0; n < 400; n++) begin
      op(($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)), $urandom,
         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
         "rand", 0, '0);
    end

    // Asynchronous reset between edges with a store pending
    op(32'h20, 32'hFFFFFFFF, 0, SW, LW, "pre_rst", 0, '0);
    @(posedge clk);
    #1;
    Addr = 32'h20; WD = 32'h00000001; MemWrite = 1'b1; StoreType = SW; LoadType = LW;
    #1;
    reset = 1'b0;
    model_clear();
    exp_q.push_back({1'b0, 32'h0}); exp_name_q.push_back("async_rst_rd");
    @(posedge clk);
    #1;
    reset = 1'b1; MemWrite = 1'b0;
    for (int i = 0; i < 16; i++)
      op(32'(i * 4), 32'h0, 0, SW, LW, "post_rst_sweep", 1, {1'b0, 32'h0});

    @(posedge clk);
    #1 MemWrite = 1'b0;
    @(negedge clk);
    #1 check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
